data_island_packet_serializer: RTL

- Sits directly downstream of the HDMI packet choice logic.
- Takes the selected packet's 24-bit header and four 56-bit subpackets, appends BCH parity, and serializes each packet over 32 pixel clocks as 9 bits per pixel for the data-island TMDS channel encoders.
- Owns the packet pixel counter and issues the per-packet strobe that the picker uses to choose the next packet.

---
 rtl/data_island_packet_serializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/data_island_packet_serializer.sv
// Data-island packet serializer: appends BCH parity to one header and four subpackets
// and streams them out as 9 bits per pixel over a 32-pixel packet.
module data_island_packet_serializer #(
    parameter logic [7:0] BCH_POLY = 8'h83
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [4:0]       packet_pixel_counter,
    output logic             packet_enable,
    output logic [8:0]       packet_data
);

    // One bit of the shift-right BCH generator shared by the header and subpacket codes.
    function automatic logic [7:0] bchStep(input logic [7:0] ecc, input logic b);
        return (ecc >> 1) ^ ((ecc[0] ^ b) ? BCH_POLY : 8'h00);
    endfunction

    logic [4:0]       counter_q, counter_d;
    logic [7:0]       eccHdr_q, eccHdr_d;
    logic [3:0][7:0]  eccSub_q, eccSub_d;

    logic [5:0]       subLoIdx;
    logic [5:0]       subHiIdx;
    logic [1:0]       parityPair;
    logic             inHeaderData;
    logic             inSubData;
    logic             lastPixel;

    assign subLoIdx     = {counter_q, 1'b0};
    assign subHiIdx     = {counter_q, 1'b1};
    assign parityPair   = counter_q[1:0];
    assign inHeaderData = (counter_q < 5'd24);
    assign inSubData    = (counter_q < 5'd28);
    assign lastPixel    = (counter_q == 5'd31);

    // Parity accumulates over the data pixels, freezes while it is being shifted out,
    // and clears at the packet boundary so the next packet starts without a bubble.
    always_comb begin
        counter_d = counter_q;
        eccHdr_d  = eccHdr_q;
        eccSub_d  = eccSub_q;
        if (!data_island_period) begin
            counter_d = 5'd0;
            eccHdr_d  = 8'h00;
            eccSub_d  = '0;
        end else begin
            counter_d = counter_q + 5'd1;
            if (lastPixel) begin
                eccHdr_d = 8'h00;
                eccSub_d = '0;
            end else begin
                if (inHeaderData) begin
                    eccHdr_d = bchStep(eccHdr_q, header[counter_q]);
                end
                if (inSubData) begin
                    for (int k = 0; k < 4; k++) begin
                        eccSub_d[k] = bchStep(bchStep(eccSub_q[k], sub[k][subLoIdx]),
                                              sub[k][subHiIdx]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            counter_q <= 5'd0;
            eccHdr_q  <= 8'h00;
            eccSub_q  <= '0;
        end else begin
            counter_q <= counter_d;
            eccHdr_q  <= eccHdr_d;
            eccSub_q  <= eccSub_d;
        end
    end

    // Output mux is purely combinational; the TMDS encoder downstream registers it.
    always_comb begin
        packet_data = 9'h000;
        if (inHeaderData) begin
            packet_data[0] = header[counter_q];
        end else begin
            packet_data[0] = eccHdr_q[counter_q[2:0]];
        end
        for (int k = 0; k < 4; k++) begin
            if (inSubData) begin
                packet_data[1 + k] = sub[k][subLoIdx];
                packet_data[5 + k] = sub[k][subHiIdx];
            end else begin
                packet_data[1 + k] = eccSub_q[k][{parityPair, 1'b0}];
                packet_data[5 + k] = eccSub_q[k][{parityPair, 1'b1}];
            end
        end
    end

    assign packet_pixel_counter = counter_q;
    assign packet_enable        = data_island_period && lastPixel;

    // Data-bit selects past the end of the header or a subpacket must never be used.
    always_comb begin
        if (inSubData) begin
            assert (subHiIdx <= 6'd55);
        end
        if (inHeaderData) begin
            assert (counter_q <= 5'd23);
        end
    end

endmodule
